button_ctrl: RTL
================

BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a button level change (min 1).
REQ-002 Parameter HOLD_CYCLES, default 50000000: cycles from a press-step until the first auto-repeat step (min 1).
REQ-003 Parameter REPEAT_CYCLES, default 10000000: cycles between successive auto-repeat steps (min 1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 buttons  input  2  raw asynchronous buttons, active-high; [0]=up, [1]=down.
REQ-007 led  output  4  current count value.
REQ-008 step  output  1  one-cycle pulse on each increment or decrement of led.
REQ-009 clr  output  1  one-cycle pulse when led is cleared by a two-button press.

Function
REQ-010 Each buttons bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each button SHALL have an independent debouncer: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreement SHALL restart the count from zero.
REQ-012 A press SHALL be the debounced level going 0->1; a release SHALL be the debounced level going 1->0.
REQ-013 Latency: led and step SHALL update exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge that samples a stable raw press.
REQ-014 Counter arithmetic SHALL be 4-bit modulo 16: 15+1 gives 0; 0-1 gives 15.
REQ-015 FSM states SHALL be IDLE, HOLD_WAIT, REPEAT, BOTH.
REQ-016 IDLE: a press of one button while the other is debounced low SHALL step led (+1 for [0], -1 for [1]), pulse step, latch direction, clear the timer, and go to HOLD_WAIT.
REQ-017 IDLE: both buttons debounced high in the same cycle SHALL set led to 0, pulse clr, and go to BOTH.
REQ-018 HOLD_WAIT: the timer SHALL increment each cycle; on reaching HOLD_CYCLES, led steps in the latched direction, step pulses, the timer clears, and the FSM goes to REPEAT.
REQ-019 REPEAT: led SHALL step every REPEAT_CYCLES cycles in the latched direction, with a step pulse each time.
REQ-020 HOLD_WAIT/REPEAT: release of the latched button SHALL return to IDLE with no step in that cycle; release has priority over a timer expiry in the same cycle.
REQ-021 HOLD_WAIT/REPEAT: the other button going debounced high SHALL clear led to 0, pulse clr, and go to BOTH; this has priority over a timer step.
REQ-022 BOTH: no steps SHALL occur; the FSM SHALL leave for IDLE only when both debounced levels are 0.
REQ-023 A release alone SHALL never change led.
REQ-024 step and clr SHALL never be high in the same cycle, and neither SHALL be high for more than one consecutive cycle except through separate events.

Reset
REQ-025 With rst high at a clk edge, the following SHALL all go to 0: led, step, clr, synchronizer flops, debounced levels, debounce counters, and the timer; the FSM SHALL go to IDLE; rst SHALL override all other inputs.
REQ-026 A button held through reset deassertion SHALL be treated as a new press after DEBOUNCE_CYCLES+3 cycles.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8)
REQ-027 Reset, then buttons[0] high for 20 cycles, then low -> led 0->1 at cycle 7 after the rise; exactly one step pulse; no clr.
REQ-028 buttons[0] toggled every 2 cycles for 20 cycles, then low -> led stays 0; no step.
REQ-029 16 short presses on [0] starting from 0 -> led=0 (wrap); then one press on [1] -> led=15.
REQ-030 Hold [0] for 36 cycles after the first step -> steps at +0, +16, +24, +32 -> led=4; after release, no further steps.
REQ-031 led=7, hold [0] past the hold time, then press [1] -> led=0 with one clr pulse; no steps while either is held; release both, press [0] -> led=1.
REQ-032 rst pulsed for 1 cycle in REPEAT with led=9 while [0] stays held -> led=0 on the next edge; led=1 at DEBOUNCE_CYCLES+3 cycles after rst falls.

Source files
------------

// File: rtl/button_ctrl.sv
// Two-button up/down counter with debounced inputs.
// Each raw button is synchronized and debounced, then a small FSM turns
// presses into single steps, a hold into auto-repeat steps, and a
// simultaneous press of both buttons into a clear of the count.
module button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] buttons,
  output logic [3:0] led,
  output logic       step,
  output logic       clr
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // One shared timer serves both the hold and the repeat interval.
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DEB_ZERO    = DW'(0);
  localparam logic [DW-1:0] DEB_ONE     = DW'(1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2,
    BOTH      = 2'd3
  } state_t;

  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [DW-1:0] r_deb_cnt [2];
  logic [1:0]    r_lvl;
  logic [1:0]    r_rise;
  state_t        r_state;
  logic          r_dir;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_led;
  logic          r_step;
  logic          r_clr;

  logic          w_dir_held;
  logic          w_other_held;
  logic [3:0]    w_led_step;

  // r_dir = 0 means counting up on button [0]; 1 means counting down on [1].
  assign w_dir_held   = r_dir ? r_lvl[1] : r_lvl[0];
  assign w_other_held = r_dir ? r_lvl[0] : r_lvl[1];
  assign w_led_step   = r_dir ? (r_led - 4'd1) : (r_led + 4'd1);

  assign led  = r_led;
  assign step = r_step;
  assign clr  = r_clr;

  // Two-flop synchronizer for the asynchronous button inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debouncer: flip only after DEBOUNCE_CYCLES disagreeing samples in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_deb_cnt[i] <= DEB_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= DEB_ZERO;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= DEB_ZERO;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_ONE;
        end
      end
    end
  end

  // Registered level and rising-edge stage feeding the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl  <= 2'b00;
      r_rise <= 2'b00;
    end else begin
      r_lvl  <= r_deb;
      r_rise <= r_deb & ~r_lvl;
    end
  end

  // Control FSM: single steps, hold/auto-repeat timing and two-button clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dir   <= 1'b0;
      r_timer <= TIMER_ZERO;
      r_led   <= 4'd0;
      r_step  <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= TIMER_ZERO;
          if (r_lvl == 2'b11) begin
            r_led   <= 4'd0;
            r_clr   <= 1'b1;
            r_state <= BOTH;
          end else if (r_rise[0] && !r_lvl[1]) begin
            r_led   <= r_led + 4'd1;
            r_step  <= 1'b1;
            r_dir   <= 1'b0;
            r_state <= HOLD_WAIT;
          end else if (r_rise[1] && !r_lvl[0]) begin
            r_led   <= r_led - 4'd1;
            r_step  <= 1'b1;
            r_dir   <= 1'b1;
            r_state <= HOLD_WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        HOLD_WAIT: begin
          // The other button wins over everything, then release, then the timer.
          if (w_other_held) begin
            r_led   <= 4'd0;
            r_clr   <= 1'b1;
            r_timer <= TIMER_ZERO;
            r_state <= BOTH;
          end else if (!w_dir_held) begin
            r_timer <= TIMER_ZERO;
            r_state <= IDLE;
          end else if (r_timer == HOLD_LAST) begin
            r_led   <= w_led_step;
            r_step  <= 1'b1;
            r_timer <= TIMER_ZERO;
            r_state <= REPEAT;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        REPEAT: begin
          if (w_other_held) begin
            r_led   <= 4'd0;
            r_clr   <= 1'b1;
            r_timer <= TIMER_ZERO;
            r_state <= BOTH;
          end else if (!w_dir_held) begin
            r_timer <= TIMER_ZERO;
            r_state <= IDLE;
          end else if (r_timer == REPEAT_LAST) begin
            r_led   <= w_led_step;
            r_step  <= 1'b1;
            r_timer <= TIMER_ZERO;
            r_state <= REPEAT;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        BOTH: begin
          // Stay parked until both buttons are fully released.
          r_timer <= TIMER_ZERO;
          if (r_lvl == 2'b00) begin
            r_state <= IDLE;
          end else begin
            r_state <= BOTH;
          end
        end
        default: begin
          r_timer <= TIMER_ZERO;
          r_state <= IDLE;
        end
      endcase
    end
  end

  button_ctrl_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .led  (r_led),
    .step (r_step),
    .clr  (r_clr)
  );

endmodule

// Output property checker for button_ctrl.
module button_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic [3:0] led,
  input logic       step,
  input logic       clr
);

  a_step_clr_excl: assert property (@(posedge clk) disable iff (rst)
    !(step && clr));

  a_led_change_flagged: assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && (led != $past(led))) |-> (step || clr));

endmodule
